// File: rtl/prog_delay_line.sv
// Runtime-programmable, ce-aware delay line with valid sideband.
// A config load clamps the new delay, flushes all valid bits and tracks refill with busy.
module prog_delay_line #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned MAX_DELAY  = 16,
  parameter int unsigned INIT_DELAY = 3,
  localparam int unsigned DW        = $clog2(MAX_DELAY + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic [WIDTH-1:0] din,
  input  logic             din_vld,
  input  logic [DW-1:0]    delay_cfg,
  input  logic             cfg_load,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  output logic             busy,
  output logic [DW-1:0]    cur_delay
);

  logic [WIDTH-1:0]     data_q [MAX_DELAY];
  logic [MAX_DELAY-1:0] vld_q;
  logic [DW-1:0]        cnt_q;
  logic [DW-1:0]        cfg_clamped_c;

  // Out-of-range requests saturate at MAX_DELAY rather than wrapping.
  always_comb begin
    cfg_clamped_c = delay_cfg;
    if (32'(delay_cfg) > MAX_DELAY) cfg_clamped_c = DW'(MAX_DELAY);
  end

  // Stage shift register; data never flushed, only the valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < int'(MAX_DELAY); i++) data_q[i] <= '0;
    end else begin
      if (ce) begin
        data_q[0] <= din;
        for (int i = 1; i < int'(MAX_DELAY); i++) data_q[i] <= data_q[i-1];
      end
      if (cfg_load) begin
        vld_q <= ce ? MAX_DELAY'(din_vld) : '0;
      end else if (ce) begin
        vld_q <= (vld_q << 1) | MAX_DELAY'(din_vld);
      end
    end
  end

  // Active delay and refill tracking; a new load restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_delay <= DW'(INIT_DELAY);
      cnt_q     <= '0;
      busy      <= 1'b0;
    end else if (cfg_load) begin
      cur_delay <= cfg_clamped_c;
      cnt_q     <= cfg_clamped_c;
      busy      <= (cfg_clamped_c != '0);
    end else if (busy && ce) begin
      cnt_q <= cnt_q - DW'(1);
      busy  <= (cnt_q != DW'(1));
    end
  end

  // Output tap: stage[d-1] for d>=1, combinational bypass for d=0.
  always_comb begin
    dout     = '0;
    dout_vld = 1'b0;
    if (cur_delay == '0) begin
      dout     = din;
      dout_vld = din_vld & ce;
    end else begin
      for (int i = 0; i < int'(MAX_DELAY); i++) begin
        if (cur_delay == DW'(i + 1)) begin
          dout     = data_q[i];
          dout_vld = vld_q[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_prog_delay_line.sv
// Directed self-checking bench for prog_delay_line with default parameters.
module tb_prog_delay_line;

  localparam int unsigned WIDTH     = 8;
  localparam int unsigned MAX_DELAY = 16;
  localparam int unsigned DW        = $clog2(MAX_DELAY + 1);

  logic             clk;
  logic             rst_n;
  logic             ce;
  logic [WIDTH-1:0] din;
  logic             din_vld;
  logic [DW-1:0]    delay_cfg;
  logic             cfg_load;
  logic [WIDTH-1:0] dout;
  logic             dout_vld;
  logic             busy;
  logic [DW-1:0]    cur_delay;

  int checks = 0;
  int errors = 0;

  prog_delay_line #(.WIDTH(WIDTH), .MAX_DELAY(MAX_DELAY), .INIT_DELAY(3)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .din(din), .din_vld(din_vld),
    .delay_cfg(delay_cfg), .cfg_load(cfg_load), .dout(dout),
    .dout_vld(dout_vld), .busy(busy), .cur_delay(cur_delay)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [DW-1:0] d, input logic [7:0] data, input logic v);
    cfg_load = 1'b1; delay_cfg = d; ce = 1'b1; din = data; din_vld = v;
    tick();
    cfg_load = 1'b0; din_vld = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ce = 1'b0; din = '0; din_vld = 1'b0; delay_cfg = '0; cfg_load = 1'b0;
    #12;
    checks++; if (dout_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got %b exp 0", dout_vld); end
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout got %h exp 00", dout); end
    checks++; if (cur_delay !== DW'(3)) begin errors++; $display("FAIL reset_cur_delay got %0d exp 3", cur_delay); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_stream();
    for (int k = 1; k <= 8; k++) begin
      din = 8'(k); din_vld = 1'b1; ce = 1'b1;
      tick();
      checks++;
      if (dout_vld !== (k >= 3)) begin errors++; $display("FAIL stream_vld k=%0d got %b exp %b", k, dout_vld, (k >= 3)); end
      if (k >= 3) begin
        checks++;
        if (dout !== 8'(k - 2)) begin errors++; $display("FAIL stream_dout k=%0d got %h exp %h", k, dout, 8'(k - 2)); end
      end
    end
    din_vld = 1'b0;
  endtask

  task automatic test_ce_gating();
    load(DW'(4), 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) begin
      ce = (i % 2 == 0) && (i != 7);
      din_vld = (i == 0);
      din = (i == 0) ? 8'hA5 : 8'h00;
      tick();
      checks++;
      if (dout_vld !== (i >= 6)) begin errors++; $display("FAIL ce_vld i=%0d got %b exp %b", i, dout_vld, (i >= 6)); end
      checks++;
      if (busy !== (i < 6)) begin errors++; $display("FAIL ce_busy i=%0d got %b exp %b", i, busy, (i < 6)); end
      if (i >= 6) begin
        checks++;
        if (dout !== 8'hA5) begin errors++; $display("FAIL ce_dout i=%0d got %h exp a5", i, dout); end
      end
    end
    ce = 1'b1; din_vld = 1'b0;
  endtask

  task automatic test_reconfig();
    load(DW'(5), 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) begin
      din = 8'h10 + 8'(i); din_vld = 1'b1; ce = 1'b1;
      tick();
    end
    checks++; if (dout_vld !== 1'b1 || dout !== 8'h13) begin errors++; $display("FAIL reconf_pre got %b/%h exp 1/13", dout_vld, dout); end
    load(DW'(2), 8'h3C, 1'b1);
    checks++; if (cur_delay !== DW'(2)) begin errors++; $display("FAIL reconf_cur got %0d exp 2", cur_delay); end
    checks++; if (dout_vld !== 1'b0) begin errors++; $display("FAIL reconf_flush got %b exp 0", dout_vld); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reconf_busy0 got %b exp 1", busy); end
    din = 8'h55; din_vld = 1'b0;
    tick();
    checks++; if (dout_vld !== 1'b1 || dout !== 8'h3C) begin errors++; $display("FAIL reconf_first got %b/%h exp 1/3c", dout_vld, dout); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reconf_busy1 got %b exp 1", busy); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reconf_busy2 got %b exp 0", busy); end
    checks++; if (dout_vld !== 1'b0) begin errors++; $display("FAIL reconf_after got %b exp 0", dout_vld); end
  endtask

  task automatic test_clamp();
    load(DW'(MAX_DELAY + 3), 8'h77, 1'b1);
    checks++; if (cur_delay !== DW'(MAX_DELAY)) begin errors++; $display("FAIL clamp_cur got %0d exp %0d", cur_delay, MAX_DELAY); end
    for (int t = 1; t <= 15; t++) begin
      din = 8'h00; din_vld = 1'b0;
      tick();
      checks++;
      if (dout_vld !== (t == 15)) begin errors++; $display("FAIL clamp_vld t=%0d got %b exp %b", t, dout_vld, (t == 15)); end
    end
    checks++; if (dout !== 8'h77) begin errors++; $display("FAIL clamp_dout got %h exp 77", dout); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clamp_busy15 got %b exp 1", busy); end
    tick();
    checks++; if (busy !== 1'b0 || dout_vld !== 1'b0) begin errors++; $display("FAIL clamp_end got busy=%b vld=%b exp 0/0", busy, dout_vld); end
  endtask

  task automatic test_bypass();
    load(DW'(0), 8'h00, 1'b0);
    checks++; if (cur_delay !== DW'(0) || busy !== 1'b0) begin errors++; $display("FAIL byp_cfg got cur=%0d busy=%b exp 0/0", cur_delay, busy); end
    din = 8'h9A; din_vld = 1'b1; ce = 1'b1;
    #1;
    checks++; if (dout !== 8'h9A || dout_vld !== 1'b1) begin errors++; $display("FAIL byp_pass got %b/%h exp 1/9a", dout_vld, dout); end
    ce = 1'b0;
    #1;
    checks++; if (dout !== 8'h9A || dout_vld !== 1'b0) begin errors++; $display("FAIL byp_ce0 got %b/%h exp 0/9a", dout_vld, dout); end
    din = 8'h21; din_vld = 1'b0; ce = 1'b1;
    #1;
    checks++; if (dout !== 8'h21 || dout_vld !== 1'b0) begin errors++; $display("FAIL byp_nv got %b/%h exp 0/21", dout_vld, dout); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL byp_busy got %b exp 0", busy); end
  endtask

  task automatic test_async_reset();
    load(DW'(6), 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) begin
      din = 8'h40 + 8'(i); din_vld = 1'b1; ce = 1'b1;
      tick();
    end
    checks++; if (dout_vld !== 1'b1 || dout !== 8'h42) begin errors++; $display("FAIL arst_pre got %b/%h exp 1/42", dout_vld, dout); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (dout_vld !== 1'b0 || dout !== 8'h00) begin errors++; $display("FAIL arst_out got %b/%h exp 0/00", dout_vld, dout); end
    checks++; if (cur_delay !== DW'(3) || busy !== 1'b0) begin errors++; $display("FAIL arst_state got cur=%0d busy=%b exp 3/0", cur_delay, busy); end
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      din = 8'h80 + 8'(k); din_vld = 1'b1; ce = 1'b1;
      tick();
      checks++;
      if (dout_vld !== (k >= 2)) begin errors++; $display("FAIL arst_vld k=%0d got %b exp %b", k, dout_vld, (k >= 2)); end
      if (k >= 2) begin
        checks++;
        if (dout !== 8'h80 + 8'(k - 2)) begin errors++; $display("FAIL arst_dout k=%0d got %h exp %h", k, dout, 8'h80 + 8'(k - 2)); end
      end
    end
    din_vld = 1'b0;
  endtask

  task automatic test_back_to_back();
    load(DW'(7), 8'h00, 1'b0);
    din = 8'hB0; din_vld = 1'b1; ce = 1'b1;
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy7 got %b exp 1", busy); end
    load(DW'(3), 8'hC0, 1'b1);
    checks++; if (cur_delay !== DW'(3) || busy !== 1'b1 || dout_vld !== 1'b0) begin
      errors++; $display("FAIL b2b_load got cur=%0d busy=%b vld=%b exp 3/1/0", cur_delay, busy, dout_vld);
    end
    for (int k = 1; k <= 3; k++) begin
      din = 8'hC0 + 8'(k); din_vld = 1'b1; ce = 1'b1;
      tick();
      checks++;
      if (busy !== (k < 3)) begin errors++; $display("FAIL b2b_busy k=%0d got %b exp %b", k, busy, (k < 3)); end
      checks++;
      if (dout_vld !== (k >= 2)) begin errors++; $display("FAIL b2b_vld k=%0d got %b exp %b", k, dout_vld, (k >= 2)); end
      if (k >= 2) begin
        checks++;
        if (dout !== 8'hC0 + 8'(k - 2)) begin errors++; $display("FAIL b2b_dout k=%0d got %h exp %h", k, dout, 8'hC0 + 8'(k - 2)); end
      end
    end
    din_vld = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_ce_gating();
    test_reconfig();
    test_clamp();
    test_bypass();
    test_async_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
